cpu_writeback: RTL and testbench

//  Write-back stage directly downstream of cpu_execute. Retires execute results

---
 rtl/cpu_writeback_pkg.sv | 23 ++
 rtl/cpu_scoreboard.sv | 56 +++++
 rtl/cpu_writeback.sv | 88 ++++++++
 tb/tb_cpu_writeback.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_writeback_pkg.sv
// Shared sizing and helpers for the cpu_writeback stage and its pending-write scoreboard.
// Optional result bypass is enabled by defining CPU_WB_BYPASS_EN.
package cpu_writeback_pkg;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;
  localparam int NREGS  = 16;
  localparam int PEND_W = 2;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // Saturating counter step; a simultaneous reserve and retire cancel out.
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cur,
                                                  input logic inc,
                                                  input logic dec);
    logic [PEND_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec && cur != PEND_MAX) nxt = cur + 1'b1;
    if (dec && !inc && cur != '0)       nxt = cur - 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/cpu_scoreboard.sv
// Per-register pending-write counters, RAW hazard detection for the two read
// ports and reserve-full indication. Bypass-aware when CPU_WB_BYPASS_EN is defined.
module cpu_scoreboard
  import cpu_writeback_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             write_en_i,
  input  logic [IDX_W-1:0] write_idx_i,
  input  logic             reserve_i,
  input  logic [IDX_W-1:0] reserve_idx_i,
  input  logic [IDX_W-1:0] rd_a_idx_i,
  input  logic [IDX_W-1:0] rd_b_idx_i,
  output logic             hazard_o,
  output logic             reserve_full_o
);

  logic [NREGS-1:0][PEND_W-1:0] pend_q;
  logic [NREGS-1:0][PEND_W-1:0] pend_d;

  function automatic logic hit(input logic [IDX_W-1:0] idx,
                               input logic [NREGS-1:0][PEND_W-1:0] pend,
                               input logic we,
                               input logic [IDX_W-1:0] widx);
    logic h;
    h = (pend[idx] != '0);
`ifdef CPU_WB_BYPASS_EN
    // The last outstanding write arriving this cycle is forwarded to the read port.
    if (we && widx == idx && pend[idx] == PEND_W'(1)) h = 1'b0;
`else
    // Without forwarding the read waits until the write has landed in the file.
    if (we && widx == idx) h = h;
`endif
    return h;
  endfunction

  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = pend_next(pend_q[r],
                            reserve_i && !stall_i && reserve_idx_i == IDX_W'(r),
                            write_en_i && write_idx_i == IDX_W'(r));
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign hazard_o       = hit(rd_a_idx_i, pend_q, write_en_i, write_idx_i) |
                          hit(rd_b_idx_i, pend_q, write_en_i, write_idx_i);
  assign reserve_full_o = (pend_q[reserve_idx_i] == PEND_MAX);

endmodule

// File: rtl/cpu_writeback.sv
// Write-back stage: 16 x 32 register file, two registered read ports and a
// pending-write scoreboard. Define CPU_WB_BYPASS_EN to forward results to the read ports.
module cpu_writeback
  import cpu_writeback_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              register_write_enable_i,
  input  logic [IDX_W-1:0]  register_write_index_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic              reserve_i,
  input  logic [IDX_W-1:0]  reserve_index_i,
  input  logic [IDX_W-1:0]  regA_index_i,
  input  logic [IDX_W-1:0]  regB_index_i,
  output logic [DATA_W-1:0] regA_o,
  output logic [DATA_W-1:0] regB_o,
  output logic              hazard_o,
  output logic              reserve_full_o
);

  logic [NREGS-1:0][DATA_W-1:0] rf_q;
  logic [NREGS-1:0][DATA_W-1:0] rf_d;
  logic [DATA_W-1:0]            rega_q, rega_d;
  logic [DATA_W-1:0]            regb_q, regb_d;

  function automatic logic [DATA_W-1:0] read_port(input logic [IDX_W-1:0] idx,
                                                  input logic [NREGS-1:0][DATA_W-1:0] rf,
                                                  input logic we,
                                                  input logic [IDX_W-1:0] widx,
                                                  input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] d;
    d = rf[idx];
`ifdef CPU_WB_BYPASS_EN
    if (we && widx == idx) d = wdata;
`else
    if (we && widx == idx) d = rf[idx];
`endif
    return d;
  endfunction

  // Writes are not gated by stall_i: execute already qualifies its enable.
  always_comb begin
    rf_d = rf_q;
    if (register_write_enable_i) rf_d[register_write_index_i] = result_i;
  end

  always_comb begin
    rega_d = rega_q;
    regb_d = regb_q;
    if (!stall_i) begin
      rega_d = read_port(regA_index_i, rf_q, register_write_enable_i,
                         register_write_index_i, result_i);
      regb_d = read_port(regB_index_i, rf_q, register_write_enable_i,
                         register_write_index_i, result_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rf_q   <= '0;
      rega_q <= '0;
      regb_q <= '0;
    end else begin
      rf_q   <= rf_d;
      rega_q <= rega_d;
      regb_q <= regb_d;
    end
  end

  assign regA_o = rega_q;
  assign regB_o = regb_q;

  cpu_scoreboard u_scoreboard (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .stall_i        (stall_i),
    .write_en_i     (register_write_enable_i),
    .write_idx_i    (register_write_index_i),
    .reserve_i      (reserve_i),
    .reserve_idx_i  (reserve_index_i),
    .rd_a_idx_i     (regA_index_i),
    .rd_b_idx_i     (regB_index_i),
    .hazard_o       (hazard_o),
    .reserve_full_o (reserve_full_o)
  );

endmodule

// File: tb/tb_cpu_writeback.sv
// Self-checking bench for cpu_writeback: directed scenarios plus randomized traffic
// against a behavioural register-file / pending-count model. Honours CPU_WB_BYPASS_EN.
module tb_cpu_writeback;

`ifdef CPU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        register_write_enable_i;
  logic [3:0]  register_write_index_i;
  logic [31:0] result_i;
  logic        reserve_i;
  logic [3:0]  reserve_index_i;
  logic [3:0]  regA_index_i;
  logic [3:0]  regB_index_i;
  logic [31:0] regA_o;
  logic [31:0] regB_o;
  logic        hazard_o;
  logic        reserve_full_o;

  cpu_writeback dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .stall_i                 (stall_i),
    .register_write_enable_i (register_write_enable_i),
    .register_write_index_i  (register_write_index_i),
    .result_i                (result_i),
    .reserve_i               (reserve_i),
    .reserve_index_i         (reserve_index_i),
    .regA_index_i            (regA_index_i),
    .regB_index_i            (regB_index_i),
    .regA_o                  (regA_o),
    .regB_o                  (regB_o),
    .hazard_o                (hazard_o),
    .reserve_full_o          (reserve_full_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  // Reference model state
  logic [31:0] m_rf [16];
  int          m_pend [16];
  logic [31:0] m_rega, m_regb;
  logic [31:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_rf[i]   = '0;
      m_pend[i] = 0;
    end
    m_rega = '0;
    m_regb = '0;
  endtask

  function automatic bit m_hit(int idx);
    bit retiring;
    retiring = register_write_enable_i && (int'(register_write_index_i) == idx);
    if (m_pend[idx] == 0) return 1'b0;
    if (BYP && retiring && m_pend[idx] == 1) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: check comb outputs, advance model at the edge, check read data.
  task automatic cycle();
    int a, b, w, r;
    bit inc_any, dec_any;
    a = int'(regA_index_i);
    b = int'(regB_index_i);
    w = int'(register_write_index_i);
    r = int'(reserve_index_i);
    #1;
    check_eq("hazard", 32'(hazard_o), 32'(m_hit(a) | m_hit(b)));
    check_eq("reserve_full", 32'(reserve_full_o), 32'(m_pend[r] == 3));
    @(posedge clk_i);
    if (!stall_i) begin
      m_rega = (BYP && register_write_enable_i && w == a) ? result_i : m_rf[a];
      m_regb = (BYP && register_write_enable_i && w == b) ? result_i : m_rf[b];
    end
    exp_q.push_back(m_rega);
    exp_q.push_back(m_regb);
    if (register_write_enable_i) m_rf[w] = result_i;
    for (int i = 0; i < 16; i++) begin
      inc_any = reserve_i && !stall_i && r == i;
      dec_any = register_write_enable_i && w == i;
      if (inc_any && !dec_any && m_pend[i] < 3) m_pend[i]++;
      if (dec_any && !inc_any && m_pend[i] > 0) m_pend[i]--;
    end
    #1;
    check_eq("regA", regA_o, exp_q.pop_front());
    check_eq("regB", regB_o, exp_q.pop_front());
    @(negedge clk_i);
  endtask

  task automatic drive(input bit st, input bit we, input int wi, input logic [31:0] res,
                       input bit rs, input int ri, input int a, input int b);
    stall_i                 = st;
    register_write_enable_i = we;
    register_write_index_i  = 4'(wi);
    result_i                = res;
    reserve_i               = rs;
    reserve_index_i         = 4'(ri);
    regA_index_i            = 4'(a);
    regB_index_i            = 4'(b);
    cycle();
  endtask

  initial begin
    int ri, wi;
    bit rs;
    rst_i = 1'b0;
    stall_i = 1'b0; register_write_enable_i = 1'b0; register_write_index_i = '0;
    result_i = '0; reserve_i = 1'b0; reserve_index_i = '0;
    regA_index_i = '0; regB_index_i = '0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check_eq("rst_regA", regA_o, 32'h0);
    check_eq("rst_regB", regB_o, 32'h0);
    check_eq("rst_hazard", 32'(hazard_o), 32'h0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Write then read r3
    drive(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0, 3, 0);
    check_eq("t2_regA", regA_o, 32'hDEADBEEF);

    // Reserve r5, read it, retire it
    drive(0, 0, 0, 32'h0, 1, 5, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 0, 5, 5);
    drive(0, 1, 5, 32'h12, 0, 0, 5, 5);
    drive(0, 0, 0, 32'h0, 0, 0, 5, 5);
    check_eq("t3_regA", regA_o, 32'h12);

    // Saturate r7, cancel inc/dec, drain
    repeat (4) drive(0, 0, 0, 32'h0, 1, 7, 7, 7);
    drive(0, 1, 7, 32'h70, 1, 7, 7, 7);
    repeat (3) drive(0, 1, 7, 32'h71, 0, 7, 7, 7);
    drive(0, 0, 0, 32'h0, 0, 7, 7, 7);

    // Stall holds outputs and ignores reserve
    drive(0, 1, 2, 32'h11, 0, 0, 2, 2);
    drive(0, 0, 0, 32'h0, 0, 0, 2, 2);
    drive(1, 1, 2, 32'h55, 1, 4, 2, 2);
    check_eq("t5_hold", regA_o, 32'h11);
    drive(0, 0, 0, 32'h0, 0, 4, 2, 4);
    check_eq("t5_regA", regA_o, 32'h55);

    // Same register on both ports; unreserved write
    drive(0, 0, 0, 32'h0, 1, 9, 0, 0);
    drive(0, 1, 9, 32'hA5A5A5A5, 0, 9, 9, 9);
    drive(0, 0, 0, 32'h0, 0, 9, 9, 9);
    check_eq("t6_regB", regB_o, 32'hA5A5A5A5);
    drive(0, 1, 9, 32'h1, 0, 9, 9, 9);
    drive(0, 0, 0, 32'h0, 0, 9, 9, 9);

    // Randomized traffic over a narrow index range to force collisions
    for (int n = 0; n < 400; n++) begin
      ri = $urandom_range(0, 7);
      wi = $urandom_range(0, 7);
      rs = ($urandom_range(0, 1) == 1) && (m_pend[ri] < 3);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, wi, $urandom,
            rs, ri, $urandom_range(0, 7), $urandom_range(0, 7));
    end

    // Asynchronous reset in the middle of the low phase with a write pending
    drive(0, 1, 1, 32'hCAFE0001, 1, 1, 1, 1);
    drive(0, 0, 0, 32'h0, 1, 1, 1, 1);
    #3 rst_i = 1'b0;
    #1;
    check_eq("mid_rst_regA", regA_o, 32'h0);
    check_eq("mid_rst_regB", regB_o, 32'h0);
    check_eq("mid_rst_hazard", 32'(hazard_o), 32'h0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int n = 0; n < 60; n++) begin
      ri = $urandom_range(0, 3);
      rs = ($urandom_range(0, 1) == 1) && (m_pend[ri] < 3);
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom, rs, ri, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
